hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the decode-stage forwarding path: decides when a value cannot yet be forwarded and holds the front end until it can.
- Keeps a 2-entry pipelined destination tracker covering the EX and MEM stages, fed by instructions issued from the IF/ID register.
- Raises stall and bubble controls for load-use hazards and for branch/jump-register hazards whose operand is read in D.
- Sits beside the decode stage and drives the PC, IF/ID and ID/EX pipeline-register enables.

Parameters:
- RETURN_ADDR_REG, 3'h7, destination register when write_sel==2'b11.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  16  instruction in IF/ID.
- id_uses_rs  in  1  instruction reads rs = instr[10:8] in EX.
- id_uses_rt  in  1  instruction reads rt = instr[7:5] in EX.
- id_rs_in_d  in  1  instruction consumes rs in D (branch/JR/JALR).
- id_reg_write  in  1  instruction writes a register.
- id_write_sel  in  2  destination select: 00→[7:5], 01→[4:2], 10→[10:8], 11→RETURN_ADDR_REG.
- id_is_load  in  1  instruction is a memory load.
- flush  in  1  taken branch/jump; kills the IF/ID instruction this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble_idex  out  1  write a NOP into ID/EX.
- stall_count  out  CNT_W  cycles with stall=1 (optional feature).
- load_use_count  out  CNT_W  load-use stall cycles (optional feature).

Behaviour:
Tracker state:
- ex_{valid,dest,load} and mem_{valid,dest,load}, all cleared asynchronously when rst_n=0.
- issue = id_valid & ~stall & ~flush.
- Every rising edge: mem_* ← ex_*. ex_* ← {issue & id_reg_write, decoded dest, id_is_load}.
- The tracker never freezes. A stall or flush inserts an invalid ex entry (a bubble).

Hazard terms (combinational from the registered tracker and the id_* inputs; rs=[10:8], rt=[7:5]):
- lu = ex_valid & ex_load & ((id_uses_rs & ex_dest==rs) | (id_uses_rt & ex_dest==rt)).
- br_ex = id_rs_in_d & ex_valid & ex_dest==rs. The EX result is not yet in EX/MEM, so the D-stage branch must wait.
- br_mem = id_rs_in_d & mem_valid & mem_load & mem_dest==rs. EX/MEM holds the load address, not the loaded data.

Outputs:
- stall = id_valid & ~flush & (lu | br_ex | br_mem).
- bubble_idex = stall | flush.
- Flush has priority: a flush in the same cycle as a hazard gives stall=0 and bubble_idex=1.
- Stall lengths: ALU result → D-branch 1 cycle; load → EX consumer 1 cycle; load → D-branch 2 cycles.
- Reset values: stall=0, bubble_idex=0 (tracker invalid, id_valid ignored), counters 0.
- Reset mid-stall: stall drops in the same cycle rst_n falls (asynchronous), and the tracker is empty afterwards.
- Writes to r0 are tracked like any other register; there is no hardwired-zero register.
- Inputs with id_valid=0 produce no stall and no issue.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_count increments each cycle stall=1.
  - load_use_count increments each cycle stall & lu.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.
- Stall behaviour is identical in both builds.

Test Plan:
1. Reset: assert rst_n=0 mid-stall with a load tracked → stall=0 immediately; after release a dependent ADD issues with no stall.
2. Load-use: LD r3 (sel=00, dest [7:5]=3), then ADD reading rs=3 → stall=1 and bubble_idex=1 for exactly 1 cycle, then the ADD issues; load_use_count=1.
3. ALU→branch: ADDI writing r2, then BEQZ r2 (id_rs_in_d=1) → 1 stall cycle; stall_count=1.
4. Load→branch: LD r4, then BNEZ r4 → 2 consecutive stall cycles (br_ex then br_mem); stall_count=2.
5. Flush priority: LD r5, then a dependent ADD while flush=1 → stall=0, bubble_idex=1, and the next ex_valid=0.
6. JAL (sel=11) writing r7, then JR r7 → 1 stall cycle. No stall when the intervening writer targets r6.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Load-use and D-stage branch hazard detector with a 2-entry EX/MEM destination tracker.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter logic [2:0] RETURN_ADDR_REG = 3'h7,
    parameter int         CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_rs_in_d,
    input  logic             id_reg_write,
    input  logic [1:0]       id_write_sel,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             bubble_idex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] load_use_count
);

    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] id_dest;
    logic       ex_valid, ex_load;
    logic [2:0] ex_dest;
    logic       mem_valid, mem_load;
    logic [2:0] mem_dest;
    logic       lu, br_ex, br_mem, issue;
    logic       unused_bits;

    assign rs          = id_instr[10:8];
    assign rt          = id_instr[7:5];
    assign unused_bits = ^{id_instr[15:11], id_instr[1:0]};

    always_comb begin
        id_dest = RETURN_ADDR_REG;
        case (id_write_sel)
            2'b00:   id_dest = id_instr[7:5];
            2'b01:   id_dest = id_instr[4:2];
            2'b10:   id_dest = id_instr[10:8];
            default: id_dest = RETURN_ADDR_REG;
        endcase
    end

    assign lu     = ex_valid & ex_load &
                    ((id_uses_rs & (ex_dest == rs)) | (id_uses_rt & (ex_dest == rt)));
    assign br_ex  = id_rs_in_d & ex_valid & (ex_dest == rs);
    // EX/MEM of a load holds its address, so a D-stage reader must wait one more cycle.
    assign br_mem = id_rs_in_d & mem_valid & mem_load & (mem_dest == rs);

    // Gating with rst_n makes both controls drop the instant reset is asserted.
    assign stall       = rst_n & id_valid & ~flush & (lu | br_ex | br_mem);
    assign bubble_idex = rst_n & (stall | flush);
    assign issue       = id_valid & ~stall & ~flush;

    // Tracker never freezes: stalls and flushes shift in an invalid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_dest   <= 3'd0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dest  <= 3'd0;
            mem_load  <= 1'b0;
        end else begin
            mem_valid <= ex_valid;
            mem_dest  <= ex_dest;
            mem_load  <= ex_load;
            ex_valid  <= issue & id_reg_write;
            ex_dest   <= id_dest;
            ex_load   <= id_is_load;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count    <= '0;
            load_use_count <= '0;
        end else begin
            if (stall)
                stall_count <= sat_inc(stall_count);
            if (stall & lu)
                load_use_count <= sat_inc(load_use_count);
        end
    end
`else
    assign stall_count    = '0;
    assign load_use_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: randomized and directed stimulus against a
// cycle-indexed issue-history model; a negedge monitor pops and compares expectations.
module tb_hazard_stall_unit;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [15:0]      id_instr = '0;
    logic             id_uses_rs = 1'b0;
    logic             id_uses_rt = 1'b0;
    logic             id_rs_in_d = 1'b0;
    logic             id_reg_write = 1'b0;
    logic [1:0]       id_write_sel = 2'b00;
    logic             id_is_load = 1'b0;
    logic             flush = 1'b0;
    logic             stall;
    logic             bubble_idex;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] load_use_count;

    hazard_stall_unit #(.RETURN_ADDR_REG(3'h7), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_in_d(id_rs_in_d),
        .id_reg_write(id_reg_write), .id_write_sel(id_write_sel), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .bubble_idex(bubble_idex),
        .stall_count(stall_count), .load_use_count(load_use_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [2:0]       dest;
        logic             load;
    } wr_rec_t;

    typedef struct {
        logic             stall;
        logic             bubble;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] lc;
        int               step;
    } exp_t;

    wr_rec_t writers[$];
    exp_t    exp_q[$];
    int      cyc = 0;
    int      step_no = 0;
    int      checks = 0;
    int      errors = 0;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_lc = '0;
    logic    last_stall = 1'b0;

    function automatic logic [15:0] mk(input int rs_r, input int rt_r, input int rd_r);
        logic [15:0] v;
        v = '0;
        v[10:8] = 3'(rs_r);
        v[7:5]  = 3'(rt_r);
        v[4:2]  = 3'(rd_r);
        return v;
    endfunction

    // Looks up the writer issued exactly 'age' cycles ago (1 = now in EX, 2 = now in MEM).
    function automatic bit find_writer(input int age, output logic [2:0] d, output logic ld);
        d = 3'd0;
        ld = 1'b0;
        foreach (writers[i])
            if (writers[i].cyc == cyc - age) begin
                d = writers[i].dest;
                ld = writers[i].load;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic evaluate();
        logic [2:0] rs_r, rt_r, dest, ed, md;
        logic el, ml, lu, hz, st;
        bit   e_ok, m_ok;
        exp_t e;
        rs_r = id_instr[10:8];
        rt_r = id_instr[7:5];
        e_ok = find_writer(1, ed, el);
        m_ok = find_writer(2, md, ml);
        lu = e_ok && el && ((id_uses_rs && ed == rs_r) || (id_uses_rt && ed == rt_r));
        hz = lu || (id_rs_in_d && e_ok && ed == rs_r) || (id_rs_in_d && m_ok && ml && md == rs_r);
        st = id_valid && !flush && hz;
        e.stall = st;
        e.bubble = st || flush;
`ifdef HAZ_PERF_CNT_EN
        e.sc = m_sc;
        e.lc = m_lc;
`else
        e.sc = '0;
        e.lc = '0;
`endif
        e.step = step_no;
        exp_q.push_back(e);
        if (st && m_sc != '1) m_sc = m_sc + 1'b1;
        if (st && lu && m_lc != '1) m_lc = m_lc + 1'b1;
        if (id_valid && !st && !flush && id_reg_write) begin
            case (id_write_sel)
                2'b00:   dest = id_instr[7:5];
                2'b01:   dest = id_instr[4:2];
                2'b10:   dest = id_instr[10:8];
                default: dest = 3'h7;
            endcase
            writers.push_back('{cyc, dest, id_is_load});
        end
        while (writers.size() > 0 && writers[0].cyc < cyc - 2) void'(writers.pop_front());
        last_stall = st;
        step_no++;
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic urs, input logic urt,
                        input logic rsd, input logic rw, input logic [1:0] sel,
                        input logic ld, input logic fl);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        id_valid = v; id_instr = ins; id_uses_rs = urs; id_uses_rt = urt;
        id_rs_in_d = rsd; id_reg_write = rw; id_write_sel = sel; id_is_load = ld; flush = fl;
        evaluate();
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges while the current inputs stay applied.
    task automatic reset_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b0;
        writers.delete();
        m_sc = '0;
        m_lc = '0;
        e.stall = 1'b0; e.bubble = 1'b0; e.sc = '0; e.lc = '0; e.step = step_no;
        exp_q.push_back(e);
        last_stall = 1'b0;
        step_no++;
    endtask

    task automatic check(input string name, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] req, input int s);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, s, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", CNT_W'(stall), CNT_W'(e.stall), e.step);
                check("bubble_idex", CNT_W'(bubble_idex), CNT_W'(e.bubble), e.step);
                check("stall_count", stall_count, e.sc, e.step);
                check("load_use_count", load_use_count, e.lc, e.step);
            end
        end
    end

    initial begin : driver
        logic v, urs, urt, rsd, rw, ld, fl;
        logic [15:0] ins;
        logic [1:0] sel;
        id_valid = 1'b1;
        id_rs_in_d = 1'b1;
        reset_cycle();
        reset_cycle();

        // Load-use: LD r3 then ADD reading r3.
        step(1, mk(1, 3, 0), 1, 0, 0, 1, 2'b00, 1, 0);
        step(1, mk(3, 2, 5), 1, 1, 0, 1, 2'b01, 0, 0);
        step(1, mk(3, 2, 5), 1, 1, 0, 1, 2'b01, 0, 0);
        idle(); idle();
        // ALU -> branch: ADDI r2 then BEQZ r2.
        step(1, mk(1, 2, 0), 1, 0, 0, 1, 2'b00, 0, 0);
        step(1, mk(2, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        step(1, mk(2, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        idle(); idle();
        // Load -> branch: LD r4 then BNEZ r4, two stall cycles.
        step(1, mk(1, 4, 0), 1, 0, 0, 1, 2'b00, 1, 0);
        repeat (3) step(1, mk(4, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        idle(); idle();
        // Flush priority, then a reader of the flushed writer's r6 must not stall.
        step(1, mk(1, 5, 0), 1, 0, 0, 1, 2'b00, 1, 0);
        step(1, mk(5, 2, 6), 1, 1, 0, 1, 2'b01, 0, 1);
        step(1, mk(6, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        idle(); idle();
        // JAL r7 then JR r7; then writer to r6 followed by JR r7.
        step(1, mk(0, 0, 0), 0, 0, 0, 1, 2'b11, 0, 0);
        step(1, mk(7, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        step(1, mk(7, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        idle(); idle();
        step(1, mk(1, 6, 0), 1, 0, 0, 1, 2'b00, 0, 0);
        step(1, mk(7, 0, 0), 0, 0, 1, 0, 2'b00, 0, 0);
        // r0 is tracked like any register.
        step(1, mk(1, 0, 0), 1, 0, 0, 1, 2'b00, 1, 0);
        step(1, mk(0, 1, 2), 1, 0, 0, 1, 2'b01, 0, 0);
        step(1, mk(0, 1, 2), 1, 0, 0, 1, 2'b01, 0, 0);
        idle(); idle();
        // Reset mid-stall with a load tracked, then the dependent ADD issues freely.
        step(1, mk(1, 3, 0), 1, 0, 0, 1, 2'b00, 1, 0);
        step(1, mk(3, 2, 5), 1, 1, 0, 1, 2'b01, 0, 0);
        reset_cycle();
        step(1, mk(3, 2, 5), 1, 1, 0, 1, 2'b01, 0, 0);
        idle();

        // Randomized traffic; a stalled instruction is held in IF/ID like real hardware.
        v = 0; ins = '0; urs = 0; urt = 0; rsd = 0; rw = 0; sel = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                v   = ($urandom_range(0, 9) < 8);
                ins = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) ins[10:8] = 3'h7;
                ins[15:11] = 5'($urandom);
                ins[1:0]   = 2'($urandom);
                urs = 1'($urandom); urt = 1'($urandom);
                rsd = ($urandom_range(0, 3) == 0);
                rw  = 1'($urandom);
                sel = 2'($urandom);
                ld  = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) reset_cycle();
            else step(v, ins, urs, urt, rsd, rw, sel, ld, fl);
        end

        idle();
        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", CNT_W'(exp_q.size()), '0, step_no);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
